// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO defaults and occupancy-width helper
package fifo_pkg;

    localparam int FIFO_DEF_DATA_WIDTH   = 12;
    localparam int FIFO_DEF_ADDR_WIDTH   = 3;
    localparam int FIFO_DEF_ALMOST_FULL  = 6;
    localparam int FIFO_DEF_ALMOST_EMPTY = 1;

    // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than an address
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - FIFO storage array, synchronous write, asynchronous read
module fifo_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: contents are never reset, only occupancy makes them meaningful
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parameterised synchronous FIFO; FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = FIFO_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = FIFO_DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL  = FIFO_DEF_ALMOST_FULL,
    parameter int ALMOST_EMPTY = FIFO_DEF_ALMOST_EMPTY
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               valid_out,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                               overflow,
    output logic                               underflow,
`endif
    output logic [cnt_width(ADDR_WIDTH)-1:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = cnt_width(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  push_ok;
    logic                  pop_ok;

    // Acceptance is judged on the current count, so full+both pops only and empty+both pushes only
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(ALMOST_FULL));
    assign almost_empty = (count <= CW'(ALMOST_EMPTY));

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Pointers, occupancy and the registered read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
                data_out <= rd_data;
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
            valid_out <= pop_ok;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - randomized self-checking bench for fifo_param against a queue model
module tb_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- default-parameter instance ----------------
    logic        reset;
    logic        push, pop;
    logic [11:0] data_in, data_out;
    logic        valid_out, full, empty, almost_full, almost_empty;
    logic [3:0]  count;
`ifdef FIFO_ERR_FLAGS_EN
    logic        overflow, underflow;
`endif

    fifo_param dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .data_in      (data_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .count        (count)
    );

    // ---------------- wide/deep instance ----------------
    logic        push2, pop2;
    logic [31:0] data_in2, data_out2;
    logic        valid_out2, full2, empty2, almost_full2, almost_empty2;
    logic [4:0]  count2;
`ifdef FIFO_ERR_FLAGS_EN
    logic        overflow2, underflow2;
`endif

    fifo_param #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (4),
        .ALMOST_FULL (14)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .push         (push2),
        .pop          (pop2),
        .data_in      (data_in2),
        .data_out     (data_out2),
        .valid_out    (valid_out2),
        .full         (full2),
        .empty        (empty2),
        .almost_full  (almost_full2),
        .almost_empty (almost_empty2),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow     (overflow2),
        .underflow    (underflow2),
`endif
        .count        (count2)
    );

    // ---------------- reference model (default instance) ----------------
    int          mq[$];
    logic [11:0] e_dout;
    logic        e_valid;
    logic        e_ovf, e_udf;

    task automatic compare_all(input string tag);
        int sz = mq.size();
        check_eq({tag, ".count"},        64'(count),        64'(sz));
        check_eq({tag, ".full"},         64'(full),         64'(sz == 8));
        check_eq({tag, ".empty"},        64'(empty),        64'(sz == 0));
        check_eq({tag, ".almost_full"},  64'(almost_full),  64'(sz >= 6));
        check_eq({tag, ".almost_empty"}, 64'(almost_empty), 64'(sz <= 1));
        check_eq({tag, ".valid_out"},    64'(valid_out),    64'(e_valid));
        check_eq({tag, ".data_out"},     64'(data_out),     64'(e_dout));
`ifdef FIFO_ERR_FLAGS_EN
        check_eq({tag, ".overflow"},     64'(overflow),     64'(e_ovf));
        check_eq({tag, ".underflow"},    64'(underflow),    64'(e_udf));
`endif
    endtask

    task automatic model_reset();
        mq.delete();
        e_dout  = '0;
        e_valid = 1'b0;
        e_ovf   = 1'b0;
        e_udf   = 1'b0;
    endtask

    // Drive one cycle, apply the queue rules at the edge, check 1 time unit later
    task automatic step(input string tag, input logic p, input logic q, input logic [11:0] d);
        int sz;
        bit ap, aq;
        push = p; pop = q; data_in = d;
        @(posedge clk);
        sz = mq.size();
        ap = p && (sz < 8);
        aq = q && (sz > 0);
        if (p && !ap) e_ovf = 1'b1;
        if (q && !aq) e_udf = 1'b1;
        e_valid = aq;
        if (aq) e_dout = 12'(mq.pop_front());
        if (ap) mq.push_back(int'(d));
        #1;
        compare_all(tag);
    endtask

    // ---------------- reference model (wide instance) ----------------
    int          mq2[$];
    logic [31:0] e_dout2;
    logic        e_valid2;

    task automatic step2(input string tag, input logic p, input logic q, input logic [31:0] d);
        int sz;
        bit ap, aq;
        push2 = p; pop2 = q; data_in2 = d;
        @(posedge clk);
        sz = mq2.size();
        ap = p && (sz < 16);
        aq = q && (sz > 0);
        e_valid2 = aq;
        if (aq) e_dout2 = 32'(mq2.pop_front());
        if (ap) mq2.push_back(int'(d));
        #1;
        sz = mq2.size();
        check_eq({tag, ".count"},       64'(count2),       64'(sz));
        check_eq({tag, ".full"},        64'(full2),        64'(sz == 16));
        check_eq({tag, ".empty"},       64'(empty2),       64'(sz == 0));
        check_eq({tag, ".almost_full"}, 64'(almost_full2), 64'(sz >= 14));
        check_eq({tag, ".valid_out"},   64'(valid_out2),   64'(e_valid2));
        check_eq({tag, ".data_out"},    64'(data_out2),    64'(e_dout2));
    endtask

    initial begin
        reset = 1'b1;
        push = 0; pop = 0; data_in = '0;
        push2 = 0; pop2 = 0; data_in2 = '0;
        e_dout2 = '0; e_valid2 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        reset = 1'b0;

        // Fill with 1..8, then a dropped push of 0x0FF
        for (int i = 1; i <= 8; i++) step("fill", 1, 0, 12'(i));
        step("push_full", 1, 0, 12'h0FF);

        // Drain in order, then an ignored pop
        for (int i = 0; i < 8; i++) step("drain", 0, 1, 12'h000);
        step("pop_empty", 0, 1, 12'h000);

        // Occupancy 4, then 20 cycles of simultaneous push/pop across the wrap
        for (int i = 0; i < 4; i++) step("pre4", 1, 0, 12'($urandom));
        for (int i = 0; i < 20; i++) step("both4", 1, 1, 12'($urandom));

        // Full plus both: pop only
        while (mq.size() < 8) step("refill", 1, 0, 12'($urandom));
        step("both_full", 1, 1, 12'h5A5);
        // Empty plus both: push only, no fall-through
        while (mq.size() > 0) step("empty_out", 0, 1, 12'h000);
        step("both_empty", 1, 1, 12'h3C3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom));
        end

        // Asynchronous reset mid-burst at count 5 with valid_out high
        while (mq.size() < 6) step("burst", 1, 0, 12'($urandom));
        while (mq.size() > 6) step("burst", 0, 1, 12'h000);
        step("burst_pop", 0, 1, 12'h000);
        #2;
        reset = 1'b1;
        push = 0; pop = 0;
        #1;
        model_reset();
        compare_all("async_reset");
        #2;
        reset = 1'b0;

        // First edges after reset behave normally
        step("post_rst", 1, 0, 12'h123);
        step("post_rst", 1, 1, 12'h456);
        step("post_rst", 0, 1, 12'h000);
        step("post_rst", 0, 0, 12'h000);
        push = 0; pop = 0;

        // Wide/deep instance: fill 16 checking almost_full onset, then drain in order
        for (int i = 0; i < 17; i++) step2("w_fill", 1, 0, $urandom);
        for (int i = 0; i < 17; i++) step2("w_drain", 0, 1, 32'h0);
        for (int i = 0; i < 200; i++) begin
            step2("w_rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end
        push2 = 0; pop2 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
